fc_layer_sched: RTL and testbench
=================================

// Module: fc_layer_sched
// PURPOSE
//  Sequences a multi-layer fully-connected inference on one CIM tile column:
//  per layer, input transfer (fc controller) -> CIM compute -> function unit.
//  Sits above the fc controller, CIM tiles and function unit; single start/done to the host.
//  Every stage uses a start/busy handshake guarded by a per-stage watchdog.
// PARAMETERS
//  num_layers      3     layers per inference run (>=1)
//  timeout_cycles  1024  max cycles any stage may take to ack or finish (>=2)
//  layer_w  $clog2(num_layers)>0 ? $clog2(num_layers) : 1   (derived, do not override)
// PORTS
//  clk             in   1        clock, rising edge
//  rst             in   1        asynchronous, active-low reset
//  i_start         in   1        start a run (sampled in S_IDLE only)
//  i_abort         in   1        synchronous abort from any state
//  o_busy          out  1        run in progress
//  o_done          out  1        1-cycle pulse: last layer's function stage finished
//  o_err           out  1        sticky watchdog error
//  o_layer         out  layer_w  current layer index
//  o_ctrl_start    out  1        start to fc controller
//  i_ctrl_busy     in   1        fc controller busy
//  o_cim_compute   out  1        start to CIM compute
//  i_cim_busy      in   1        CIM busy
//  o_func_start    out  1        start to function unit
//  i_func_busy     in   1        function unit busy
// BEHAVIOUR
//  Reset (rst=0): state S_IDLE, all outputs 0, layer 0, watchdog 0; takes effect immediately.
//  States: S_IDLE, S_LD_ACK, S_LD_WAIT, S_CP_ACK, S_CP_WAIT, S_FN_ACK, S_FN_WAIT, S_NEXT, S_ERR.
//  S_IDLE: i_start=1 -> S_LD_ACK, layer<=0. o_busy=0.
//  *_ACK: hold stage start high (registered) until its busy=1 seen, then -> *_WAIT, start low same edge.
//  *_WAIT: wait for busy=0, then LD->S_CP_ACK, CP->S_FN_ACK, FN->S_NEXT.
//  Busy already high on ACK entry counts as ack in first cycle (min 1 cycle per ACK state).
//  S_NEXT (1 cycle): layer==num_layers-1 -> o_done=1 next cycle, layer<=0, S_IDLE; else layer+1, S_LD_ACK.
//  o_busy=1 in every state except S_IDLE and S_ERR; o_done asserted only on the S_NEXT->S_IDLE edge.
//  Exactly one stage start high at a time; all starts 0 outside *_ACK.
//  Watchdog: cleared on every state change; counts in *_ACK/*_WAIT; at timeout_cycles -> S_ERR.
//  S_ERR: o_err=1, starts 0, o_busy=0; i_start ignored; leave only via i_abort or reset.
//  i_abort=1: next state S_IDLE, o_err<=0, layer<=0, starts drop next cycle; abort beats start/timeout.
//  Busy deasserting and timeout in same cycle: handshake wins (no error).
//  All outputs registered; zero combinational input->output paths.
// CONFIGURATION
//  FC_LAYER_SCHED_PERF_EN defined: extra port o_cycles out 32: cleared on accepted start,
//   +1 each busy cycle, saturates at 2^32-1, frozen from o_done until next start; abort clears.
//  Not defined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  fc_layer_sched_pkg: sched_state_t enum, stage_t enum {STG_LD,STG_CP,STG_FN}.
//  Sub-module fc_layer_sched_wdog: clear/enable inputs, timeout_cycles param, o_expired.
//  Top: state register + next-state comb, layer counter, output registers.
// TESTING
//  num_layers=3, stages ack in 1 cycle, busy 5 cycles -> 3x(LD,CP,FN), o_done once, o_layer 0,1,2,0.
//  i_cim_busy stuck 0 on layer 1, timeout_cycles=16 -> S_ERR after 16 cycles, o_err=1, o_busy=0.
//  In S_ERR, i_start=1 -> ignored; i_abort=1 -> S_IDLE, o_err=0 next cycle, restart succeeds.
//  i_abort during S_FN_WAIT layer 2 -> o_func_start=0, o_layer=0, no o_done.
//  rst low mid S_CP_WAIT -> all outputs 0 immediately, S_IDLE after release.
//  PERF_EN, busy 5 cycles per stage, num_layers=1 -> o_cycles frozen at measured count, stable after done.

Source files
------------

// File: rtl/fc_layer_sched_pkg.sv
// Shared types for the fully-connected layer scheduler.
// Holds the scheduler state encoding, the stage identifiers and small
// helpers that classify a state by stage and by handshake phase.
package fc_layer_sched_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 4'd0,
        S_LD_ACK  = 4'd1,
        S_LD_WAIT = 4'd2,
        S_CP_ACK  = 4'd3,
        S_CP_WAIT = 4'd4,
        S_FN_ACK  = 4'd5,
        S_FN_WAIT = 4'd6,
        S_NEXT    = 4'd7,
        S_ERR     = 4'd8
    } sched_state_t;

    typedef enum logic [1:0] {
        STG_LD = 2'd0,
        STG_CP = 2'd1,
        STG_FN = 2'd2
    } stage_t;

    // Which downstream unit a state is talking to (LD for non-stage states).
    function automatic stage_t state_stage(input sched_state_t s);
        stage_t stg;
        case (s)
            S_CP_ACK, S_CP_WAIT: stg = STG_CP;
            S_FN_ACK, S_FN_WAIT: stg = STG_FN;
            default:             stg = STG_LD;
        endcase
        return stg;
    endfunction

    // True in the states where the watchdog is allowed to count.
    function automatic logic is_handshake(input sched_state_t s);
        return (s == S_LD_ACK) || (s == S_LD_WAIT) ||
               (s == S_CP_ACK) || (s == S_CP_WAIT) ||
               (s == S_FN_ACK) || (s == S_FN_WAIT);
    endfunction

endpackage

// File: rtl/fc_layer_sched_wdog.sv
// Per-stage watchdog for the layer scheduler.
// Counts cycles spent in one handshake state; o_expired is high during the
// cycle that is the timeout_cycles-th cycle of that state, so the owner can
// leave for the error state on the following edge.
module fc_layer_sched_wdog #(
    parameter int timeout_cycles = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic o_expired
);

    localparam int CW = $clog2(timeout_cycles + 1);
    localparam logic [CW-1:0] LIMIT = CW'(timeout_cycles - 1);

    logic [CW-1:0] count;

    // Cycle counter: cleared on every state change, holds at the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != LIMIT)) begin
            count <= count + CW'(1);
        end
    end

    assign o_expired = en && (count == LIMIT);

endmodule

// File: rtl/fc_layer_sched.sv
// Multi-layer fully-connected inference sequencer for one CIM tile column.
// Per layer it runs input transfer (fc controller), CIM compute and the
// function unit in turn, each through a start/busy handshake guarded by a
// watchdog, and reports a single done pulse to the host.
// Optional cycle counter port o_cycles is built when FC_LAYER_SCHED_PERF_EN
// is defined.
//
// Stage handshake: the scheduler raises a stage start and holds it until it
// samples that stage's busy high (busy already high counts on the first
// cycle); start drops on the same edge the scheduler moves to the wait
// state, which then lasts until busy is sampled low. No other stage start
// is ever high at the same time.
module fc_layer_sched
    import fc_layer_sched_pkg::*;
#(
    parameter int num_layers     = 3,
    parameter int timeout_cycles = 1024,
    parameter int layer_w        = ($clog2(num_layers) > 0) ? $clog2(num_layers) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic               i_abort,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err,
    output logic [layer_w-1:0] o_layer,
    output logic               o_ctrl_start,
    input  logic               i_ctrl_busy,
    output logic               o_cim_compute,
    input  logic               i_cim_busy,
    output logic               o_func_start,
    input  logic               i_func_busy,
    output logic [STATE_W-1:0] o_state
`ifdef FC_LAYER_SCHED_PERF_EN
    ,
    output logic [31:0]        o_cycles
`endif
);

    localparam logic [layer_w-1:0] LAST_LAYER = layer_w'(num_layers - 1);

    sched_state_t       state;
    sched_state_t       state_next;
    logic [layer_w-1:0] layer_next;
    logic               done_next;
    logic               stg_busy;
    logic               wd_clr;
    logic               wd_en;
    logic               wd_expired;

    // Select the busy flag of the unit the current state is talking to.
    always_comb begin
        stg_busy = 1'b0;
        case (state_stage(state))
            STG_LD:  stg_busy = i_ctrl_busy;
            STG_CP:  stg_busy = i_cim_busy;
            STG_FN:  stg_busy = i_func_busy;
            default: stg_busy = 1'b0;
        endcase
    end

    assign wd_clr = (state_next != state);
    assign wd_en  = is_handshake(state);

    fc_layer_sched_wdog #(
        .timeout_cycles(timeout_cycles)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .clr      (wd_clr),
        .en       (wd_en),
        .o_expired(wd_expired)
    );

    // Next-state, next-layer and done decode; handshake beats timeout,
    // abort beats everything.
    always_comb begin
        state_next = state;
        layer_next = o_layer;
        done_next  = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_next = S_LD_ACK;
                    layer_next = '0;
                end
            end
            S_LD_ACK: begin
                if (stg_busy)        state_next = S_LD_WAIT;
                else if (wd_expired) state_next = S_ERR;
            end
            S_LD_WAIT: begin
                if (!stg_busy)       state_next = S_CP_ACK;
                else if (wd_expired) state_next = S_ERR;
            end
            S_CP_ACK: begin
                if (stg_busy)        state_next = S_CP_WAIT;
                else if (wd_expired) state_next = S_ERR;
            end
            S_CP_WAIT: begin
                if (!stg_busy)       state_next = S_FN_ACK;
                else if (wd_expired) state_next = S_ERR;
            end
            S_FN_ACK: begin
                if (stg_busy)        state_next = S_FN_WAIT;
                else if (wd_expired) state_next = S_ERR;
            end
            S_FN_WAIT: begin
                if (!stg_busy)       state_next = S_NEXT;
                else if (wd_expired) state_next = S_ERR;
            end
            S_NEXT: begin
                if (o_layer == LAST_LAYER) begin
                    state_next = S_IDLE;
                    layer_next = '0;
                    done_next  = 1'b1;
                end else begin
                    state_next = S_LD_ACK;
                    layer_next = o_layer + layer_w'(1);
                end
            end
            S_ERR: begin
                state_next = S_ERR;
            end
            default: begin
                state_next = S_IDLE;
                layer_next = '0;
            end
        endcase
        if (i_abort) begin
            state_next = S_IDLE;
            layer_next = '0;
            done_next  = 1'b0;
        end
    end

    // State, layer and all host/stage outputs registered from the decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            o_layer       <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_err         <= 1'b0;
            o_ctrl_start  <= 1'b0;
            o_cim_compute <= 1'b0;
            o_func_start  <= 1'b0;
        end else begin
            state         <= state_next;
            o_layer       <= layer_next;
            o_busy        <= (state_next != S_IDLE) && (state_next != S_ERR);
            o_done        <= done_next;
            o_err         <= (state_next == S_ERR);
            o_ctrl_start  <= (state_next == S_LD_ACK);
            o_cim_compute <= (state_next == S_CP_ACK);
            o_func_start  <= (state_next == S_FN_ACK);
        end
    end

    assign o_state = state;

`ifdef FC_LAYER_SCHED_PERF_EN
    // Run-length counter: cleared by abort or an accepted start, counts
    // busy cycles, saturates, and holds once the run stops being busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_cycles <= '0;
        end else if (i_abort) begin
            o_cycles <= '0;
        end else if ((state == S_IDLE) && i_start) begin
            o_cycles <= '0;
        end else if (o_busy && (o_cycles != 32'hFFFF_FFFF)) begin
            o_cycles <= o_cycles + 32'd1;
        end
    end
`else
    // No cycle counter in this build.
`endif

endmodule

// File: tb/tb_fc_layer_sched.sv
// Bench for fc_layer_sched: 3 layers, 16-cycle watchdog, behavioural stage
// responders that ack one cycle after start and stay busy a set length.
module tb_fc_layer_sched;
    import fc_layer_sched_pkg::*;

    localparam int NL = 3;
    localparam int TO = 16;

    logic       clk;
    logic       rst;
    logic       i_start;
    logic       i_abort;
    logic       o_busy;
    logic       o_done;
    logic       o_err;
    logic [1:0] o_layer;
    logic       o_ctrl_start;
    logic       i_ctrl_busy;
    logic       o_cim_compute;
    logic       i_cim_busy;
    logic       o_func_start;
    logic       i_func_busy;
    logic [3:0] o_state;
`ifdef FC_LAYER_SCHED_PERF_EN
    logic [31:0] o_cycles;
`endif

    fc_layer_sched #(
        .num_layers    (NL),
        .timeout_cycles(TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err),
        .o_layer      (o_layer),
        .o_ctrl_start (o_ctrl_start),
        .i_ctrl_busy  (i_ctrl_busy),
        .o_cim_compute(o_cim_compute),
        .i_cim_busy   (i_cim_busy),
        .o_func_start (o_func_start),
        .i_func_busy  (i_func_busy),
        .o_state      (o_state)
`ifdef FC_LAYER_SCHED_PERF_EN
        ,
        .o_cycles     (o_cycles)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- stage responders ----------------
    int ld_len = 5, cp_len = 5, fn_len = 5;
    int ld_cnt = 0, cp_cnt = 0, fn_cnt = 0;
    int cim_stuck_layer = -1;

    initial begin
        i_ctrl_busy = 1'b0;
        i_cim_busy  = 1'b0;
        i_func_busy = 1'b0;
    end

    always @(negedge clk) begin
        if (ld_cnt > 0) begin
            ld_cnt--;
            if (ld_cnt == 0) i_ctrl_busy = 1'b0;
        end else if (o_ctrl_start) begin
            i_ctrl_busy = 1'b1;
            ld_cnt = ld_len;
        end
    end

    always @(negedge clk) begin
        if (cp_cnt > 0) begin
            cp_cnt--;
            if (cp_cnt == 0) i_cim_busy = 1'b0;
        end else if (o_cim_compute && (int'(o_layer) != cim_stuck_layer)) begin
            i_cim_busy = 1'b1;
            cp_cnt = cp_len;
        end
    end

    always @(negedge clk) begin
        if (fn_cnt > 0) begin
            fn_cnt--;
            if (fn_cnt == 0) i_func_busy = 1'b0;
        end else if (o_func_start) begin
            i_func_busy = 1'b1;
            fn_cnt = fn_len;
        end
    end

    // ---------------- scoreboard ----------------
    // Event code {kind, layer}: kind 1=LD start, 2=CP start, 3=FN start, 0=done.
    logic [7:0] exp_q[$];
    bit sb_en = 1'b0;
    logic prev_ld = 1'b0, prev_cp = 1'b0, prev_fn = 1'b0;

    task automatic sb_check(input string name, input logic [7:0] act);
        logic [7:0] exp;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s: got event %h with empty expected queue", name, act);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                n_errors++;
                $display("FAIL %s: got event %h expected %h", name, act, exp);
            end
        end
    endtask

    always @(negedge clk) begin
        int ones;
        if (sb_en) begin
            if (o_ctrl_start && !prev_ld)  sb_check("ld_start", {2'd1, 6'(o_layer)});
            if (o_cim_compute && !prev_cp) sb_check("cp_start", {2'd2, 6'(o_layer)});
            if (o_func_start && !prev_fn)  sb_check("fn_start", {2'd3, 6'(o_layer)});
            if (o_done)                    sb_check("done",     {2'd0, 6'(o_layer)});
        end
        if (rst) begin
            ones = int'(o_ctrl_start) + int'(o_cim_compute) + int'(o_func_start);
            n_checks++;
            if (ones > 1) begin
                n_errors++;
                $display("FAIL one_start: got %0d starts high expected at most 1", ones);
            end
        end
        prev_ld = o_ctrl_start;
        prev_cp = o_cim_compute;
        prev_fn = o_func_start;
    end

    // ---------------- driver tasks ----------------
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    // Full run with scoreboarding; returns busy cycles seen and done flag.
    task automatic run_once(input int ld, input int cp, input int fn,
                            output int cyc, output bit got_done);
        ld_len = ld;
        cp_len = cp;
        fn_len = fn;
        cyc = 0;
        got_done = 1'b0;
        for (int l = 0; l < NL; l++) begin
            exp_q.push_back({2'd1, 6'(l)});
            exp_q.push_back({2'd2, 6'(l)});
            exp_q.push_back({2'd3, 6'(l)});
        end
        exp_q.push_back(8'h00);
        sb_en = 1'b1;
        pulse_start();
        for (int i = 0; i < 1000; i++) begin
            if (o_done) begin
                got_done = 1'b1;
                break;
            end
            if (o_busy) cyc++;
            @(negedge clk);
        end
        @(negedge clk);
        sb_en = 1'b0;
        chk("done_pulse_low", 32'(o_done), 32'd0);
    endtask

    typedef struct {
        int ld;
        int cp;
        int fn;
        int exp_cyc;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int  cyc;
        bit  ok;
        bit  found;
        int  done_cnt;

        // Each stage costs len+1 cycles, plus one S_NEXT cycle per layer.
        vecs[0] = '{ld: 5, cp: 5, fn: 5, exp_cyc: 57};
        vecs[1] = '{ld: 1, cp: 1, fn: 1, exp_cyc: 21};
        vecs[2] = '{ld: 2, cp: 7, fn: 3, exp_cyc: 48};
        vecs[3] = '{ld: 3, cp: 1, fn: 6, exp_cyc: 42};

        rst = 1'b0;
        i_start = 1'b0;
        i_abort = 1'b0;
        idle_cycles(3);
        chk("rst_busy",  32'(o_busy), 32'd0);
        chk("rst_done",  32'(o_done), 32'd0);
        chk("rst_err",   32'(o_err), 32'd0);
        chk("rst_layer", 32'(o_layer), 32'd0);
        chk("rst_starts", 32'({o_ctrl_start, o_cim_compute, o_func_start}), 32'd0);
        chk("rst_state", 32'(o_state), 32'(S_IDLE));
        rst = 1'b1;
        idle_cycles(2);

        // Table of full runs.
        for (int v = 0; v < 4; v++) begin
            idle_cycles(10);
            run_once(vecs[v].ld, vecs[v].cp, vecs[v].fn, cyc, ok);
            chk($sformatf("run%0d_done", v), 32'(ok), 32'd1);
            chk($sformatf("run%0d_cycles", v), 32'(cyc), 32'(vecs[v].exp_cyc));
            chk($sformatf("run%0d_queue", v), 32'(exp_q.size()), 32'd0);
            chk($sformatf("run%0d_idle", v), 32'(o_state), 32'(S_IDLE));
            chk($sformatf("run%0d_layer", v), 32'(o_layer), 32'd0);
`ifdef FC_LAYER_SCHED_PERF_EN
            chk($sformatf("run%0d_perf", v), o_cycles, 32'(vecs[v].exp_cyc));
            idle_cycles(5);
            chk($sformatf("run%0d_perf_hold", v), o_cycles, 32'(vecs[v].exp_cyc));
`endif
            exp_q.delete();
        end

        // Watchdog: CIM never acks on layer 1.
        idle_cycles(10);
        ld_len = 5; cp_len = 5; fn_len = 5;
        cim_stuck_layer = 1;
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (o_cim_compute && (o_layer == 2'd1)) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("to_reached_cp1", 32'(found), 32'd1);
        idle_cycles(TO - 1);
        chk("to_err_before", 32'(o_err), 32'd0);
        chk("to_busy_before", 32'(o_busy), 32'd1);
        chk("to_cim_before", 32'(o_cim_compute), 32'd1);
        @(negedge clk);
        chk("to_err", 32'(o_err), 32'd1);
        chk("to_busy", 32'(o_busy), 32'd0);
        chk("to_cim", 32'(o_cim_compute), 32'd0);
        chk("to_state", 32'(o_state), 32'(S_ERR));
        i_start = 1'b1;
        idle_cycles(3);
        i_start = 1'b0;
        chk("err_start_ignored", 32'(o_state), 32'(S_ERR));
        chk("err_sticky", 32'(o_err), 32'd1);
        chk("err_busy", 32'(o_busy), 32'd0);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        chk("abort_err_clr", 32'(o_err), 32'd0);
        chk("abort_err_idle", 32'(o_state), 32'(S_IDLE));
        cim_stuck_layer = -1;
        idle_cycles(10);
        exp_q.delete();
        run_once(5, 5, 5, cyc, ok);
        chk("restart_done", 32'(ok), 32'd1);
        chk("restart_cycles", 32'(cyc), 32'd57);
        exp_q.delete();

        // Abort in S_FN_WAIT of the last layer.
        idle_cycles(10);
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if ((o_state == 4'(S_FN_WAIT)) && (o_layer == 2'd2)) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("ab_reached_fn2", 32'(found), 32'd1);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        chk("ab_func_start", 32'(o_func_start), 32'd0);
        chk("ab_layer", 32'(o_layer), 32'd0);
        chk("ab_busy", 32'(o_busy), 32'd0);
        chk("ab_state", 32'(o_state), 32'(S_IDLE));
        done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (o_done) done_cnt++;
            @(negedge clk);
        end
        chk("ab_no_done", 32'(done_cnt), 32'd0);

        // Abort while the function start is being held.
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (o_func_start) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("abk_reached_fn", 32'(found), 32'd1);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        chk("abk_func_start", 32'(o_func_start), 32'd0);
        chk("abk_state", 32'(o_state), 32'(S_IDLE));
        idle_cycles(10);

        // Asynchronous reset in the middle of S_CP_WAIT.
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (o_state == 4'(S_CP_WAIT)) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("rs_reached_cp", 32'(found), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("rs_outputs", 32'({o_busy, o_done, o_err, o_ctrl_start, o_cim_compute,
                               o_func_start, o_layer, o_state}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rs_idle", 32'(o_state), 32'(S_IDLE));
        chk("rs_busy", 32'(o_busy), 32'd0);
        idle_cycles(10);
        exp_q.delete();
        run_once(2, 2, 2, cyc, ok);
        chk("rs_restart_done", 32'(ok), 32'd1);
        chk("rs_restart_cycles", 32'(cyc), 32'd30);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
